// File: rtl/l1_i_fetch_unit.sv
// l1_i_fetch_unit: instruction fetch stage in front of L1_I.
// Holds the PC and issues sequential 32-bit fetches over the tag/index/offset
// and read_C_L1/stall handshake. Returned instructions go into a small FIFO
// toward decode. Handles branch redirects (including redirects that arrive
// during an outstanding miss) and fence.i-driven L1_I flushes.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   tag_C_L1            pc[31 -: TNUM]
//   index_C_L1          pc[6 +: INUM]
//   offset              pc[5:0]
//   read_C_L1           fetch request to L1_I
//   flush               one-cycle L1_I invalidate pulse
//   stall               L1_I busy (miss in progress)
//   read_data_L1_C      instruction returned by L1_I
//   instr_valid         queue head valid
//   instr, instr_pc     queue head instruction and its PC
//   instr_ready         decode accepts the head
//   redirect            branch/jump redirect pulse
//   redirect_pc         redirect / fence.i target (bits[1:0] forced to 0)
//   fence_i             flush L1_I, then refetch from redirect_pc
module l1_i_fetch_unit #(
    parameter int unsigned TNUM     = 21,
    parameter int unsigned INUM     = 26 - TNUM,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [TNUM-1:0] tag_C_L1,
    output logic [INUM-1:0] index_C_L1,
    output logic [5:0]      offset,
    output logic            read_C_L1,
    output logic            flush,
    input  logic            stall,
    input  logic [31:0]     read_data_L1_C,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [31:0]     instr_pc,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    input  logic            fence_i
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_FLUSH
    } state_t;

    state_t          state;
    logic [31:0]     pc;
    logic [31:0]     target;
    logic            discard;
    logic            fence_pend;

    logic [31:0]     q_data [QDEPTH];
    logic [31:0]     q_pc   [QDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            fire;
    logic            miss_out;
    logic            ctrl;
    logic            push;
    logic            pop;
    logic [31:0]     target_in;
    logic [CW-1:0]   count_nxt;

    // Low PC bits of the target are always forced to zero.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

    // Address fields come straight from the PC register.
    assign tag_C_L1   = pc[31 -: TNUM];
    assign index_C_L1 = pc[6 +: INUM];
    assign offset     = pc[5:0];

    // Queue head is visible as soon as an entry exists.
    assign instr_valid = (count != '0);
    assign instr       = q_data[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];

    // Handshake decode for the current cycle.
    always_comb begin
        fire      = read_C_L1 && !stall;
        miss_out  = read_C_L1 && stall;
        ctrl      = ((state == ST_FETCH) || (state == ST_DRAIN)) && (redirect || fence_i);
        push      = (state == ST_FETCH) && fire && !ctrl && !discard;
        pop       = instr_valid && instr_ready && !ctrl;
        target_in = {redirect_pc[31:2], 2'b00};
        count_nxt = count;
        if (ctrl) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CW'(push) - CW'(pop);
        end
    end

    // Instruction queue storage and pointers; redirect/fence clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (ctrl) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    q_data[wr_ptr] <= read_data_L1_C;
                    q_pc[wr_ptr]   <= pc;
                    wr_ptr         <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    // Fetch control FSM; read_C_L1 and flush are registered from next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            target     <= '0;
            discard    <= 1'b0;
            fence_pend <= 1'b0;
            read_C_L1  <= 1'b0;
            flush      <= 1'b0;
        end else begin
            flush <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state     <= ST_FETCH;
                    read_C_L1 <= 1'b1;
                end

                ST_FETCH: begin
                    if (fence_i) begin
                        target <= target_in;
                        if (miss_out) begin
                            // Let the outstanding miss finish before flushing.
                            state      <= ST_DRAIN;
                            discard    <= 1'b1;
                            fence_pend <= 1'b1;
                            read_C_L1  <= 1'b1;
                        end else begin
                            state     <= ST_FLUSH;
                            read_C_L1 <= 1'b0;
                            flush     <= 1'b1;
                        end
                    end else if (redirect) begin
                        if (miss_out) begin
                            // Cannot abandon the miss: park the target until it returns.
                            target    <= target_in;
                            discard   <= 1'b1;
                            state     <= ST_DRAIN;
                            read_C_L1 <= 1'b1;
                        end else begin
                            pc        <= target_in;
                            read_C_L1 <= 1'b1;
                        end
                    end else begin
                        if (fire) begin
                            pc <= pc + 32'd4;
                        end
                        // A pop frees a slot, but fetching only resumes next cycle.
                        read_C_L1 <= (count_nxt < FULL);
                    end
                end

                ST_DRAIN: begin
                    if (fence_i) begin
                        target     <= target_in;
                        fence_pend <= 1'b1;
                    end else if (redirect) begin
                        target <= target_in;
                    end
                    if (!stall) begin
                        // Returning data belongs to the abandoned path and is dropped.
                        discard <= 1'b0;
                        if (fence_pend || fence_i) begin
                            state     <= ST_FLUSH;
                            read_C_L1 <= 1'b0;
                            flush     <= 1'b1;
                        end else begin
                            pc        <= redirect ? target_in : target;
                            state     <= ST_FETCH;
                            read_C_L1 <= 1'b1;
                        end
                    end
                end

                ST_FLUSH: begin
                    pc         <= target;
                    fence_pend <= 1'b0;
                    state      <= ST_FETCH;
                    read_C_L1  <= 1'b1;
                end

                default: begin
                    state     <= ST_IDLE;
                    read_C_L1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_i_fetch_unit.sv
module tb_l1_i_fetch_unit;

    logic        clk;
    logic        rst;
    logic [20:0] tag_C_L1;
    logic [4:0]  index_C_L1;
    logic [5:0]  offset;
    logic        read_C_L1;
    logic        flush;
    logic        stall;
    logic [31:0] read_data_L1_C;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fence_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          failures;
    logic        mon_en;
    logic        drop_pending;
    logic [31:0] model_pc;
    logic [31:0] fetch_addr;

    l1_i_fetch_unit #(
        .TNUM(21),
        .RESET_PC(32'h0000_1000),
        .QDEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tag_C_L1(tag_C_L1),
        .index_C_L1(index_C_L1),
        .offset(offset),
        .read_C_L1(read_C_L1),
        .flush(flush),
        .stall(stall),
        .read_data_L1_C(read_data_L1_C),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .fence_i(fence_i)
    );

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        if (a == 32'h0000_1040) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_F00D;
    endfunction

    assign fetch_addr     = {tag_C_L1, index_C_L1, offset};
    assign read_data_L1_C = exp_data(fetch_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard: predict pushes from completed fetches, compare pops at the head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (flush) begin
                checks++;
                if (read_C_L1 !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_vs_read: read_C_L1=%b required 0 while flush=1", read_C_L1);
                end
            end
            if (instr_valid && instr_ready && !redirect && !fence_i) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL pop_unexpected: got pc=%h instr=%h with nothing expected", instr_pc, instr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (instr_pc !== e.pc || instr !== e.data) begin
                        failures++;
                        $display("FAIL pop_data: got pc=%h instr=%h required pc=%h instr=%h",
                                 instr_pc, instr, e.pc, e.data);
                    end
                end
            end
            if (read_C_L1 && !stall && !redirect && !fence_i) begin
                if (drop_pending) begin
                    drop_pending = 1'b0;
                end else begin
                    checks++;
                    if (fetch_addr !== model_pc) begin
                        failures++;
                        $display("FAIL fetch_addr: got %h required %h", fetch_addr, model_pc);
                    end
                    sb.push_back('{pc: model_pc, data: exp_data(model_pc)});
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        step();
        redirect    = 1'b1;
        redirect_pc = tgt;
        model_pc    = {tgt[31:2], 2'b00};
        sb.delete();
        step();
        redirect = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; instr_ready = 1'b1; redirect = 1'b0;
        redirect_pc = '0; fence_i = 1'b0; mon_en = 1'b0; drop_pending = 1'b0;
        model_pc = 32'h0000_1000;
        repeat (2) @(negedge clk);
        checks++;
        if (read_C_L1 !== 1'b0 || flush !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: read=%b flush=%b valid=%b required 0 0 0", read_C_L1, flush, instr_valid);
        end
        checks++;
        if (instr !== 32'h0 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_head: instr=%h instr_pc=%h required 0 0", instr, instr_pc);
        end
        checks++;
        if (fetch_addr !== 32'h0000_1000) begin
            failures++;
            $display("FAIL reset_pc: got %h required 00001000", fetch_addr);
        end
        step();
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if (read_C_L1 !== 1'b0) begin
            failures++;
            $display("FAIL idle_read: got %b required 0 in first cycle after reset", read_C_L1);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ea;
            ea = 32'h0000_1000 + 32'(4 * i);
            @(negedge clk);
            checks++;
            if (read_C_L1 !== 1'b1 || fetch_addr !== ea || offset !== ea[5:0]) begin
                failures++;
                $display("FAIL seq_fetch[%0d]: read=%b addr=%h off=%h required 1 %h %h",
                         i, read_C_L1, fetch_addr, offset, ea, ea[5:0]);
            end
        end
    endtask

    task automatic test_miss();
        do_redirect(32'h0000_1040);
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (read_C_L1 !== 1'b1 || fetch_addr !== 32'h0000_1040 || index_C_L1 !== 5'd1 || offset !== 6'd0) begin
                failures++;
                $display("FAIL miss_hold[%0d]: read=%b addr=%h idx=%h off=%h required 1 00001040 01 00",
                         i, read_C_L1, fetch_addr, index_C_L1, offset);
            end
        end
        step();
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'hDEAD_BEEF || instr_pc !== 32'h0000_1040 || fetch_addr !== 32'h0000_1044) begin
            failures++;
            $display("FAIL miss_result: valid=%b instr=%h pc=%h next=%h required 1 deadbeef 00001040 00001044",
                     instr_valid, instr, instr_pc, fetch_addr);
        end
    endtask

    task automatic test_backpressure();
        int n;
        step();
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1800;
        model_pc    = 32'h0000_1800;
        sb.delete();
        step();
        redirect = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (read_C_L1 && !stall) n++;
        end
        checks++;
        if (n != 4 || read_C_L1 !== 1'b0 || instr_pc !== 32'h0000_1800) begin
            failures++;
            $display("FAIL bp_fill: fetches=%0d read=%b head=%h required 4 0 00001800", n, read_C_L1, instr_pc);
        end
        step();
        instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (read_C_L1 !== 1'b0) begin
            failures++;
            $display("FAIL bp_full_pop: read=%b required 0 while full", read_C_L1);
        end
        step();
        instr_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (read_C_L1 !== 1'b1 || instr_pc !== 32'h0000_1804 || fetch_addr !== 32'h0000_1810) begin
            failures++;
            $display("FAIL bp_resume: read=%b head=%h addr=%h required 1 00001804 00001810",
                     read_C_L1, instr_pc, fetch_addr);
        end
        @(negedge clk);
        checks++;
        if (read_C_L1 !== 1'b0) begin
            failures++;
            $display("FAIL bp_refull: read=%b required 0", read_C_L1);
        end
    endtask

    task automatic test_redirect_miss();
        instr_ready = 1'b1;
        do_redirect(32'h0000_2000);
        stall = 1'b1;
        @(negedge clk);
        checks++;
        if (fetch_addr !== 32'h0000_2000 || read_C_L1 !== 1'b1 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_start: addr=%h read=%b valid=%b required 00002000 1 0", fetch_addr, read_C_L1, instr_valid);
        end
        step();
        redirect     = 1'b1;
        redirect_pc  = 32'h0000_3003;
        model_pc     = 32'h0000_3000;
        drop_pending = 1'b1;
        sb.delete();
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (fetch_addr !== 32'h0000_2000 || read_C_L1 !== 1'b1 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL rm_drain[%0d]: addr=%h read=%b valid=%b required 00002000 1 0",
                         i, fetch_addr, read_C_L1, instr_valid);
            end
        end
        step();
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (fetch_addr !== 32'h0000_3000 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_dropped: addr=%h valid=%b required 00003000 0", fetch_addr, instr_valid);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_3000) begin
            failures++;
            $display("FAIL rm_first: valid=%b pc=%h required 1 00003000", instr_valid, instr_pc);
        end
    endtask

    task automatic test_fence();
        step();
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3800;
        model_pc    = 32'h0000_3800;
        sb.delete();
        step();
        redirect = 1'b0;
        repeat (3) @(negedge clk);
        step();
        fence_i     = 1'b1;
        redirect_pc = 32'h0000_4000;
        model_pc    = 32'h0000_4000;
        sb.delete();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_3800) begin
            failures++;
            $display("FAIL fence_queue: valid=%b head=%h required 1 00003800", instr_valid, instr_pc);
        end
        step();
        fence_i = 1'b0;
        @(negedge clk);
        checks++;
        if (flush !== 1'b1 || read_C_L1 !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL fence_flush: flush=%b read=%b valid=%b required 1 0 0", flush, read_C_L1, instr_valid);
        end
        @(negedge clk);
        checks++;
        if (flush !== 1'b0 || read_C_L1 !== 1'b1 || fetch_addr !== 32'h0000_4000) begin
            failures++;
            $display("FAIL fence_resume: flush=%b read=%b addr=%h required 0 1 00004000", flush, read_C_L1, fetch_addr);
        end
        step();
        instr_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap_and_reset();
        do_redirect(32'hFFFF_FFFC);
        @(negedge clk);
        checks++;
        if (fetch_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_top: addr=%h required fffffffc", fetch_addr);
        end
        @(negedge clk);
        checks++;
        if (fetch_addr !== 32'h0000_0000) begin
            failures++;
            $display("FAIL wrap_zero: addr=%h required 00000000", fetch_addr);
        end
        step();
        stall = 1'b1;
        @(negedge clk);
        checks++;
        if (read_C_L1 !== 1'b1 || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: read=%b valid=%b required 1 1", read_C_L1, instr_valid);
        end
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        checks++;
        if (read_C_L1 !== 1'b0 || instr_valid !== 1'b0 || fetch_addr !== 32'h0000_1000) begin
            failures++;
            $display("FAIL async_reset: read=%b valid=%b addr=%h required 0 0 00001000",
                     read_C_L1, instr_valid, fetch_addr);
        end
        sb.delete();
        step();
        rst   = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sequential();
        test_miss();
        test_backpressure();
        test_redirect_miss();
        test_fence();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
